gmii_rx_framer: RTL and testbench



---
 rtl/gmii_rx_framer.sv | 192 +++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks CRC-32 and length, drops FCS.
// Optional statistics counters are enabled with `define GMII_RX_STAT_EN.
module gmii_rx_framer #(
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1522,
    parameter int MAX_PREAMBLE = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rx_d,
    input  logic        gmii_rx_err,
`ifdef GMII_RX_STAT_EN
    input  logic        stat_clr,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_err,
    output logic [31:0] cnt_drop,
`endif
    output logic        o_valid,
    output logic [7:0]  o_data,
    output logic        o_sop,
    output logic        o_eop,
    output logic [2:0]  o_err
);

    localparam int          PW      = $clog2(MAX_PREAMBLE + 1);
    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pre_cnt, pre_n;
    logic [4:0][7:0] sr, sr_n;
    logic [15:0]     len, len_n;
    logic [31:0]     crc, crc_n;
    logic            gerr, gerr_n;
    logic            rst_q;
    logic            emit, sop_n, eop_n;
    logic [2:0]      err_n;

    // MSB-first register fed LSB-first bits: the mirror image of the reflected CRC
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[31] ^ b[i];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        state_n = state;
        pre_n   = pre_cnt;
        sr_n    = sr;
        len_n   = len;
        crc_n   = crc;
        gerr_n  = gerr;
        emit    = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        err_n   = 3'b000;
        unique case (state)
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (!rst_q && gmii_rx_d == 8'h55) begin
                        state_n = PREAMBLE;
                        pre_n   = PW'(1);
                    end else begin
                        state_n = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_n = IDLE;
                end else if (gmii_rx_d == 8'hD5) begin
                    state_n = DATA;
                    len_n   = 16'd0;
                    crc_n   = 32'hFFFF_FFFF;
                end else if (gmii_rx_d == 8'h55 && pre_cnt < PW'(MAX_PREAMBLE)) begin
                    pre_n = pre_cnt + PW'(1);
                end else begin
                    state_n = DROP;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    sr_n  = {sr[3:0], gmii_rx_d};
                    crc_n = crc_step(crc, gmii_rx_d);
                    len_n = (len == 16'hFFFF) ? len : len + 16'd1;
                    if (gmii_rx_err)
                        gerr_n = 1'b1;
                    if (len >= 16'd5) begin
                        emit  = 1'b1;
                        sop_n = (len == 16'd5);
                    end
                    // overlength: close the frame on the byte leaving now, drop the rest
                    if (len == 16'(MAX_LEN)) begin
                        eop_n   = 1'b1;
                        err_n   = {gerr | gmii_rx_err, 1'b1, 1'b0};
                        state_n = DROP;
                    end
                end else begin
                    state_n = IDLE;
                    if (len >= 16'd5) begin
                        emit  = 1'b1;
                        sop_n = (len == 16'd5);
                        eop_n = 1'b1;
                        err_n = {gerr, len < 16'(MIN_LEN), crc != RESIDUE};
                    end
                end
            end
            DROP: begin
                if (!gmii_rx_dv)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE)
            gerr_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            rst_q   <= 1'b1;
            pre_cnt <= '0;
            sr      <= '0;
            len     <= '0;
            crc     <= '0;
            gerr    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= 8'h00;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_err   <= 3'b000;
        end else begin
            state   <= state_n;
            rst_q   <= 1'b0;
            pre_cnt <= pre_n;
            sr      <= sr_n;
            len     <= len_n;
            crc     <= crc_n;
            gerr    <= gerr_n;
            o_valid <= emit;
            o_sop   <= sop_n;
            o_eop   <= eop_n;
            o_err   <= err_n;
            if (emit)
                o_data <= sr[4];
        end
    end

`ifdef GMII_RX_STAT_EN
    logic drop_ev, good_q, bad_q, drop_q;

    // DATA->DROP is an overlength frame, already counted as an error at its eop
    assign drop_ev = (state != DROP && state != DATA && state_n == DROP) ||
                     (state == DATA && !gmii_rx_dv && len < 16'd5);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            good_q   <= 1'b0;
            bad_q    <= 1'b0;
            drop_q   <= 1'b0;
            cnt_good <= '0;
            cnt_err  <= '0;
            cnt_drop <= '0;
        end else begin
            good_q <= eop_n && (err_n == 3'b000);
            bad_q  <= eop_n && (err_n != 3'b000);
            drop_q <= drop_ev;
            if (stat_clr) begin
                cnt_good <= '0;
                cnt_err  <= '0;
                cnt_drop <= '0;
            end else begin
                if (good_q && cnt_good != '1)
                    cnt_good <= cnt_good + 32'd1;
                if (bad_q && cnt_err != '1)
                    cnt_err <= cnt_err + 32'd1;
                if (drop_q && cnt_drop != '1)
                    cnt_drop <= cnt_drop + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Randomised scoreboard bench for gmii_rx_framer with a frame-level reference model.
// Build with +define+GMII_RX_STAT_EN to also check the statistics counters.
module tb_gmii_rx_framer;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       dv      = 1'b0;
    logic [7:0] d       = 8'h00;
    logic       er      = 1'b0;
    logic       o_valid, o_sop, o_eop;
    logic [7:0] o_data;
    logic [2:0] o_err;
`ifdef GMII_RX_STAT_EN
    logic        stat_clr = 1'b0;
    logic [31:0] cnt_good, cnt_err, cnt_drop;
`endif

    gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .MAX_PREAMBLE(7)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .gmii_rx_dv(dv),
        .gmii_rx_d(d),
        .gmii_rx_err(er),
`ifdef GMII_RX_STAT_EN
        .stat_clr(stat_clr),
        .cnt_good(cnt_good),
        .cnt_err(cnt_err),
        .cnt_drop(cnt_drop),
`endif
        .o_valid(o_valid),
        .o_data(o_data),
        .o_sop(o_sop),
        .o_eop(o_eop),
        .o_err(o_err)
    );

    always #4 clk = ~clk;

    int unsigned cyc = 0;
    logic        rst_edge = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !reset_n;
    end

    typedef struct {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic [2:0]  err;
        int unsigned cyc;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         passes = 0;
    int         m_good = 0, m_err = 0, m_drop = 0;

    // monitor: every cycle either a reset check, a scoreboard pop, or idle flags
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                checks++;
                if ({o_valid, o_sop, o_eop, o_err, o_data} == 14'd0) passes++;
                else $display("FAIL reset_outputs: got v=%b sop=%b eop=%b err=%b d=%h, want all 0",
                              o_valid, o_sop, o_eop, o_err, o_data);
            end else if (o_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    $display("FAIL unexpected_byte at cyc %0d: got d=%h sop=%b eop=%b err=%b, want nothing",
                             cyc, o_data, o_sop, o_eop, o_err);
                end else begin
                    e = expq.pop_front();
                    if ({o_data, o_sop, o_eop, o_err} === {e.d, e.sop, e.eop, e.err}) passes++;
                    else $display("FAIL byte: got d=%h sop=%b eop=%b err=%b, want d=%h sop=%b eop=%b err=%b",
                                  o_data, o_sop, o_eop, o_err, e.d, e.sop, e.eop, e.err);
                    checks++;
                    if (cyc == e.cyc) passes++;
                    else $display("FAIL latency: got edge %0d, want edge %0d", cyc, e.cyc);
                end
            end else begin
                checks++;
                if ({o_sop, o_eop, o_err} == 5'd0) passes++;
                else $display("FAIL idle_flags: got sop=%b eop=%b err=%b, want 0", o_sop, o_eop, o_err);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] b, input logic e_in, output int unsigned smp);
        @(negedge clk);
        dv  = v;
        d   = b;
        er  = e_in;
        smp = cyc + 1;
    endtask

    task automatic gap(input int n);
        int unsigned s;
        repeat (n) drive(1'b0, 8'h00, 1'b0, s);
    endtask

    // standard Ethernet FCS over the first n bytes of frm (reflected CRC, complemented)
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input int len);
        logic [31:0] c;
        frm.delete();
        if (len <= 4) begin
            for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
        end else begin
            for (int i = 0; i < len - 4; i++) frm.push_back(8'($urandom));
            c = fcs_of(len - 4);
            frm.push_back(c[7:0]);
            frm.push_back(c[15:8]);
            frm.push_back(c[23:16]);
            frm.push_back(c[31:24]);
        end
    endtask

    task automatic preamble(output int unsigned t0);
        int unsigned s;
        repeat (7) drive(1'b1, 8'h55, 1'b0, s);
        drive(1'b1, 8'hD5, 1'b0, s);
        t0 = s + 1;
    endtask

    // expected stream from the frame rules: payload = L-4 bytes, eop carries status
    task automatic send_frame(input int err_at);
        int unsigned t0, s;
        int          L, n_out;
        logic [2:0]  err;
        logic [31:0] rx_fcs;
        L = frm.size();
        preamble(t0);
        if (L > MAX_LEN) begin
            n_out = MAX_LEN - 4;
            err   = {err_at >= 0 && err_at <= MAX_LEN, 1'b1, 1'b0};
        end else if (L >= 5) begin
            n_out  = L - 4;
            rx_fcs = {frm[L-1], frm[L-2], frm[L-3], frm[L-4]};
            err    = {err_at >= 0 && err_at < L, L < MIN_LEN, fcs_of(L - 4) != rx_fcs};
        end else begin
            n_out = 0;
            err   = 3'b000;
        end
        for (int i = 0; i < n_out; i++)
            expq.push_back('{frm[i], i == 0, i == n_out - 1,
                             (i == n_out - 1) ? err : 3'b000, t0 + i + 5});
        if (n_out == 0) m_drop++;
        else if (err == 3'b000) m_good++;
        else m_err++;
        for (int i = 0; i < L; i++) drive(1'b1, frm[i], i == err_at, s);
        gap($urandom_range(1, 3));
    endtask

    task automatic send_raw(input int n55, input logic [7:0] bad);
        int unsigned s;
        repeat (n55) drive(1'b1, 8'h55, 1'b0, s);
        drive(1'b1, bad, 1'b0, s);
        repeat (20) drive(1'b1, 8'($urandom), 1'b0, s);
        m_drop++;
        gap(1);
    endtask

    task automatic send_reset_mid(input int k);
        int unsigned t0;
        build_frame(70);
        preamble(t0);
        for (int i = 0; i <= k - 6; i++)
            expq.push_back('{frm[i], i == 0, 1'b0, 3'b000, t0 + i + 5});
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge clk);
            reset_n = (i != k);
            dv      = 1'b1;
            d       = frm[i];
            er      = 1'b0;
        end
        m_good = 0;
        m_err  = 0;
        m_drop = 1;
        gap(2);
    endtask

    initial begin
        int len;
        int eat;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        build_frame(64);
        send_frame(-1);
        frm[10] ^= 8'h04;
        send_frame(-1);
        build_frame(40);
        send_frame(-1);
        build_frame(4);
        send_frame(-1);
        build_frame(1);
        send_frame(-1);
        build_frame(5);
        send_frame(-1);
        build_frame(1600);
        send_frame(-1);
        send_raw(2, 8'h12);
        send_raw(8, 8'hD5);
        send_raw(0, 8'hD5);
        build_frame(100);
        send_frame(20);
        build_frame(MAX_LEN);
        send_frame(-1);

        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(5, 200);
            build_frame(len);
            if ($urandom_range(0, 3) == 0)
                frm[$urandom_range(0, len - 1)] ^= 8'h01 << $urandom_range(0, 7);
            eat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            send_frame(eat);
        end

        send_reset_mid($urandom_range(10, 30));
        build_frame(64);
        send_frame(-1);
        gap(12);

        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL missing_bytes: got %0d undelivered, want 0", expq.size());

`ifdef GMII_RX_STAT_EN
        checks++;
        if (cnt_good == 32'(m_good)) passes++;
        else $display("FAIL cnt_good: got %0d, want %0d", cnt_good, m_good);
        checks++;
        if (cnt_err == 32'(m_err)) passes++;
        else $display("FAIL cnt_err: got %0d, want %0d", cnt_err, m_err);
        checks++;
        if (cnt_drop == 32'(m_drop)) passes++;
        else $display("FAIL cnt_drop: got %0d, want %0d", cnt_drop, m_drop);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({cnt_good, cnt_err, cnt_drop} == 96'd0) passes++;
        else $display("FAIL stat_clr: got %0d/%0d/%0d, want 0/0/0", cnt_good, cnt_err, cnt_drop);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
